alu_cmd_issuer: RTL

Initiator-side companion to the 4-bit combinational ALU. It accepts operation commands over a valid/ready interface and buffers them in a small FIFO. It drives the ALU operand/op lines, holds them stable for a settle cycle, samples result and flags, and returns them over a valid/ready response interface. It also keeps sticky flags and an operation counter for the debug/status path.

---
 rtl/alu_cmd_issuer_if.sv | 36 +++
 rtl/alu_cmd_issuer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_issuer_if.sv
// ---------------------------------------------------------------------------
// alu_cmd_issuer_if
// Command and response channels of the ALU command issuer.
//   cmd_valid/cmd_ready : command handshake (initiator -> issuer)
//   cmd_op/cmd_a/cmd_b  : command payload (op code, operands)
//   rsp_valid/rsp_ready : response handshake (issuer -> consumer)
//   rsp_data/rsp_flags  : captured ALU result and {carry, overflow, zero}
// master : the side that sends commands and consumes responses
// slave  : the issuer itself
// ---------------------------------------------------------------------------
interface alu_cmd_issuer_if #(
  parameter int DATA_W = 4
) ();

  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_op;
  logic [DATA_W-1:0] cmd_a;
  logic [DATA_W-1:0] cmd_b;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic [2:0]        rsp_flags;

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_flags
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_flags
  );

endinterface

// File: rtl/alu_cmd_issuer.sv
// ---------------------------------------------------------------------------
// alu_cmd_issuer
// Initiator-side companion to a combinational ALU. Commands are queued in a
// small FIFO, driven onto the ALU, held for one settle cycle, sampled and
// returned over a valid/ready response channel. Sticky flags and a completed
// operation counter are kept for status/debug.
//
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   bus (slave)     : command and response channels (see alu_cmd_issuer_if)
//   alu_a/b/op      : operands and op code driven to the ALU (registered)
//   alu_out         : ALU result
//   alu_zero/overflow/carry : ALU flags
//   sticky_flags    : OR of flags of all accepted responses {carry,ovf,zero}
//   sticky_clr      : clears sticky_flags (wins over a same-cycle merge)
//   op_count        : number of accepted responses, wraps
// ---------------------------------------------------------------------------
module alu_cmd_issuer #(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  alu_cmd_issuer_if.slave   bus,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_op,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_zero,
  input  logic              alu_overflow,
  input  logic              alu_carry,
  output logic [2:0]        sticky_flags,
  input  logic              sticky_clr,
  output logic [CNT_W-1:0]  op_count
);

  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [2:0]        op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } cmd_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_SAMPLE,
    S_RESP
  } state_e;

  // -------------------------------------------------------------------------
  // Command FIFO
  // -------------------------------------------------------------------------
  cmd_t        mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        full, empty;
  logic        push, pop;
  cmd_t        head;

  // The extra MSB differs when the writer has lapped the reader once.
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign push  = bus.cmd_valid && !full;
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  assign wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
  assign rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define which
  // entries are valid, so clearing the array would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= '{op: bus.cmd_op, a: bus.cmd_a, b: bus.cmd_b};
    end
  end

  // -------------------------------------------------------------------------
  // Sequencing FSM
  // -------------------------------------------------------------------------
  state_e state_q, state_d;
  logic   capture;
  logic   rsp_hs;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (!empty) state_d = S_DRIVE;
      S_DRIVE:  state_d = S_SAMPLE;
      S_SAMPLE: state_d = S_RESP;
      S_RESP:   if (bus.rsp_ready) state_d = empty ? S_IDLE : S_DRIVE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pop     = 1'b0;
    capture = 1'b0;
    rsp_hs  = 1'b0;
    unique case (state_q)
      S_IDLE:   pop = !empty;
      S_SAMPLE: capture = 1'b1;
      // Back-to-back: the next command is popped on the handshake edge so
      // the following response needs only DRIVE and SAMPLE again.
      S_RESP: begin
        rsp_hs = bus.rsp_ready;
        pop    = bus.rsp_ready && !empty;
      end
      default: ;
    endcase
  end

  // -------------------------------------------------------------------------
  // ALU drive, response capture, status
  // -------------------------------------------------------------------------
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic [2:0]        alu_op_q, alu_op_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic [2:0]        rsp_flags_q, rsp_flags_d;
  logic [2:0]        sticky_q, sticky_d;
  logic [CNT_W-1:0]  count_q, count_d;

  always_comb begin
    alu_a_d     = pop ? head.a  : alu_a_q;
    alu_b_d     = pop ? head.b  : alu_b_q;
    alu_op_d    = pop ? head.op : alu_op_q;
    rsp_data_d  = capture ? alu_out : rsp_data_q;
    rsp_flags_d = capture ? {alu_carry, alu_overflow, alu_zero} : rsp_flags_q;
    rsp_valid_d = rsp_valid_q;
    if (capture)     rsp_valid_d = 1'b1;
    else if (rsp_hs) rsp_valid_d = 1'b0;
    // A clear in the same cycle as a handshake drops that response's flags.
    if (sticky_clr)  sticky_d = '0;
    else if (rsp_hs) sticky_d = sticky_q | rsp_flags_q;
    else             sticky_d = sticky_q;
    count_d = rsp_hs ? count_q + 1'b1 : count_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_flags_q <= '0;
      sticky_q    <= '0;
      count_q     <= '0;
    end else begin
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_flags_q <= rsp_flags_d;
      sticky_q    <= sticky_d;
      count_q     <= count_d;
    end
  end

  assign bus.cmd_ready = !full;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_flags = rsp_flags_q;
  assign alu_a         = alu_a_q;
  assign alu_b         = alu_b_q;
  assign alu_op        = alu_op_q;
  assign sticky_flags  = sticky_q;
  assign op_count      = count_q;

endmodule
